// File: rtl/tms_io_panel_if.sv
// Pin-level bundle between a TMS1100-style CPU and its front panel.
// The panel drives K, the display and key_any; the CPU side drives R, O and the raw key matrix.
interface tms_io_panel_if;
   logic [10:0] pins_r;
   logic [7:0]  pins_o;
   logic [43:0] keys;
   logic [3:0]  pins_k;
   logic [10:0] digit_sel;
   logic [7:0]  segments;
   logic        key_any;

   modport master (
      output pins_r, pins_o, keys,
      input  pins_k, digit_sel, segments, key_any
   );

   modport slave (
      input  pins_r, pins_o, keys,
      output pins_k, digit_sel, segments, key_any
   );
endinterface

// File: rtl/tms_io_panel.sv
// Front-panel peripheral for a TMS1100: latches O patterns per R strobe, multiplexes them
// onto an LED display, and returns debounced key-matrix K lines for the active R strobes.
module tms_io_panel #(
   parameter int NUM_DIGITS    = 11,
   parameter int SETTLE_CYCLES = 64,
   parameter int SCAN_DIV      = 1024,
   parameter int BLANK_CYCLES  = 8,
   parameter int DEBOUNCE_DIV  = 4096
) (
   input  logic          raw_clk,
   input  logic          reset,
   tms_io_panel_if.slave bus
);

   localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
   localparam int SLOT_W   = $clog2(SCAN_DIV);
   localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DIV_W    = $clog2(DEBOUNCE_DIV);

   localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES);
   localparam logic [SETTLE_W-1:0] SETTLE_HIT = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [SLOT_W-1:0]   SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0]   BLANK_END  = SLOT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(DEBOUNCE_DIV - 1);

   // CPU-side resynchronisers and capture state
   logic [10:0]         r_meta, r_s;
   logic [7:0]          o_meta, o_s;
   logic [18:0]         ro_prev;
   logic                ro_changed;
   logic [SETTLE_W-1:0] settle_cnt;
   logic [7:0]          seg_mem [NUM_DIGITS];

   // Refresh state
   logic [SLOT_W-1:0]   slot_cnt;
   logic [IDX_W-1:0]    idx;

   // Debounce and K return
   logic [DIV_W-1:0]    div_cnt;
   logic [43:0]         key_sample, key_prev, key_db, key_diff;
   logic [3:0]          k_next;

   assign ro_changed = ({r_s, o_s} != ro_prev);

   // A digit is written once per stable period, when the settle counter passes SETTLE_CYCLES-1.
   always_ff @(posedge raw_clk) begin
      if (reset) begin
         r_meta     <= '0;
         r_s        <= '0;
         o_meta     <= '0;
         o_s        <= '0;
         ro_prev    <= '0;
         settle_cnt <= '0;
         // NOTE: seg_mem is a small flop array, not a RAM, so it is cleared with everything else.
         for (int i = 0; i < NUM_DIGITS; i++) seg_mem[i] <= '0;
      end else begin
         r_meta  <= bus.pins_r;
         r_s     <= r_meta;
         o_meta  <= bus.pins_o;
         o_s     <= o_meta;
         ro_prev <= {r_s, o_s};
         if (ro_changed) settle_cnt <= '0;
         else if (settle_cnt < SETTLE_MAX) settle_cnt <= settle_cnt + 1'b1;
         if (!ro_changed && settle_cnt == SETTLE_HIT) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (r_s[i]) seg_mem[i] <= o_s;
            end
         end
      end
   end

   // Each slot opens with BLANK_CYCLES of dark segments so the previous digit does not ghost.
   always_ff @(posedge raw_clk) begin
      if (reset) begin
         slot_cnt      <= '0;
         idx           <= '0;
         bus.digit_sel <= '0;
         bus.segments  <= '0;
      end else begin
         if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end
         bus.digit_sel <= 11'(1) << idx;
         bus.segments  <= (slot_cnt < BLANK_END) ? 8'h00 : seg_mem[idx];
      end
   end

   // A key bit only moves when two consecutive samples agree.
   always_comb begin
      // NOTE: defaults first so no path through this block can infer a latch.
      key_diff = key_sample ^ key_prev;
      k_next   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_s[i]) k_next = k_next | key_db[4*i +: 4];
      end
   end

   always_ff @(posedge raw_clk) begin
      if (reset) begin
         div_cnt     <= '0;
         key_sample  <= '0;
         key_prev    <= '0;
         key_db      <= '0;
         bus.pins_k  <= '0;
         bus.key_any <= 1'b0;
      end else begin
         if (div_cnt == DIV_LAST) begin
            div_cnt    <= '0;
            key_sample <= bus.keys;
            key_prev   <= key_sample;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
         key_db      <= (key_sample & ~key_diff) | (key_db & key_diff);
         bus.pins_k  <= k_next;
         bus.key_any <= |key_db;
      end
   end

endmodule

// File: tb/tb_tms_io_panel.sv
// Self-checking bench for tms_io_panel: expected display/K values are queued when stimulus
// is applied and compared when the panel presents them.
module tb_tms_io_panel;

   localparam int SCAN  = 1024;
   localparam int DEB   = 4096;
   localparam int ND    = 11;
   localparam int LIMIT = 2 * ND * SCAN + 16;

   logic raw_clk = 1'b0;
   logic reset   = 1'b1;
   always #5 raw_clk = ~raw_clk;

   tms_io_panel_if bus ();

   tms_io_panel dut (
      .raw_clk (raw_clk),
      .reset   (reset),
      .bus     (bus)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge raw_clk);
      #1;
   endtask

   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic pop_check(input string tag, input logic [31:0] got);
      if (exp_q.size() == 0) check({tag, "_sb"}, 32'(exp_q.size()), 1);
      else check(tag, got, exp_q.pop_front());
   endtask

   // Returns at the first sample where digit k is enabled (slot cycle 0).
   task automatic wait_digit(input int k, output int steps, output logic [10:0] prev_sel);
      logic [10:0] target;
      target   = 11'(1) << k;
      steps    = 0;
      prev_sel = bus.digit_sel;
      while (bus.digit_sel == target && steps < LIMIT) begin
         step(1);
         steps++;
      end
      while (bus.digit_sel != target && steps < LIMIT) begin
         prev_sel = bus.digit_sel;
         step(1);
         steps++;
      end
      if (bus.digit_sel != target) check($sformatf("wait_d%0d", k), 32'(bus.digit_sel), 32'(target));
   endtask

   task automatic show_digit(input string tag, input int k);
      int          s;
      int          nz;
      logic [10:0] p;
      wait_digit(k, s, p);
      nz = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.segments != 8'h00) nz++;
         if (i < 7) step(1);
      end
      check({tag, "_blank"}, 32'(nz), 0);
      step(1);
      pop_check(tag, 32'(bus.segments));
   endtask

   task automatic wait_key(input logic level, output int s);
      s = 0;
      while (bus.key_any !== level && s < 3 * DEB) begin
         step(1);
         s++;
      end
      if (bus.key_any !== level) check("key_wait", 32'(bus.key_any), 32'(level));
   endtask

   task automatic set_r(input logic [10:0] r, input logic [3:0] k_exp, input string tag);
      bus.pins_r = r;
      push(32'(k_exp));
      step(4);
      pop_check(tag, 32'(bus.pins_k));
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          nz;
      int          s;
      logic [10:0] p;

      bus.pins_r = '0;
      bus.pins_o = '0;
      bus.keys   = '0;
      reset      = 1'b1;
      step(5);
      check("rst_sel", 32'(bus.digit_sel), 0);
      check("rst_seg", 32'(bus.segments), 0);
      check("rst_k",   32'(bus.pins_k), 0);
      check("rst_any", 32'(bus.key_any), 0);

      // First slot after release: digit 0 selected, segments dark.
      reset = 1'b0;
      step(1);
      check("rel_sel", 32'(bus.digit_sel), 32'h001);
      nz = 0;
      for (int i = 0; i < SCAN; i++) begin
         if (bus.segments != 8'h00 || bus.digit_sel != 11'h001) nz++;
         step(1);
      end
      check("slot0_dark", 32'(nz), 0);

      // Single-digit capture into digit 2.
      bus.pins_r = 11'h004;
      bus.pins_o = 8'h6D;
      push(32'h6D);
      step(100);
      bus.pins_r = '0;
      show_digit("d2", 2);

      // Unstable O never captures; then a stable value lands exactly 2+64 cycles later.
      push(32'h00);
      wait_digit(0, s, p);
      step(10);
      pop_check("d0_old", 32'(bus.segments));
      bus.pins_r = 11'h001;
      nz = 0;
      for (int t = 0; t < 8; t++) begin
         bus.pins_o = t[0] ? 8'h22 : 8'h11;
         for (int c = 0; c < 30; c++) begin
            step(1);
            if (bus.segments != 8'h00) nz++;
         end
      end
      check("toggle_nocap", 32'(nz), 0);
      bus.pins_o = 8'h3F;
      push(32'h00);
      push(32'h3F);
      step(67);
      pop_check("lat_early", 32'(bus.segments));
      step(1);
      pop_check("lat_hit", 32'(bus.segments));
      bus.pins_r = '0;

      // Two R lines at once, then refresh period check across the 10 -> 0 wrap.
      bus.pins_r = 11'h081;
      bus.pins_o = 8'h7F;
      push(32'h7F);
      push(32'h7F);
      step(100);
      bus.pins_r = '0;
      show_digit("d7", 7);
      show_digit("d0", 0);
      wait_digit(0, s, p);
      check("wrap_period", 32'(s + 8), 32'(ND * SCAN));
      check("wrap_prev",   32'(p), 32'h400);

      // Debounced keys: R3/K1, R0/K0, R10/K3.
      bus.keys     = '0;
      bus.keys[13] = 1'b1;
      bus.keys[0]  = 1'b1;
      bus.keys[43] = 1'b1;
      wait_key(1'b1, s);
      check("press_lat", 32'(s >= DEB + 3 && s <= 2 * DEB + 2), 1);
      set_r(11'h008, 4'h2, "k_r3");
      set_r(11'h001, 4'h1, "k_r0");
      set_r(11'h009, 4'h3, "k_r0r3");
      set_r(11'h400, 4'h8, "k_r10");
      bus.pins_r = 11'h010;
      push(32'h8);
      push(32'h0);
      step(2);
      pop_check("k_hold", 32'(bus.pins_k));
      step(1);
      pop_check("k_r4", 32'(bus.pins_k));
      set_r(11'h000, 4'h0, "k_none");

      // Release, then a 100-cycle glitch placed over a sample point.
      bus.keys = '0;
      wait_key(1'b0, s);
      bus.pins_r = 11'h008;
      step(DEB - 2 - 50);
      bus.keys[13] = 1'b1;
      step(100);
      bus.keys[13] = 1'b0;
      nz = 0;
      for (int i = 0; i < 2 * DEB + 16; i++) begin
         step(1);
         if (bus.key_any != 1'b0 || bus.pins_k != 4'h0) nz++;
      end
      check("glitch", 32'(nz), 0);

      // Reset in the middle of a capture and with a key held.
      bus.keys[13] = 1'b1;
      wait_key(1'b1, s);
      bus.pins_r = 11'h00A;
      bus.pins_o = 8'h5B;
      step(43);
      check("pre_rst_k", 32'(bus.pins_k), 32'h2);
      reset      = 1'b1;
      bus.pins_r = '0;
      bus.pins_o = '0;
      step(1);
      check("rst2_sel", 32'(bus.digit_sel), 0);
      check("rst2_seg", 32'(bus.segments), 0);
      check("rst2_k",   32'(bus.pins_k), 0);
      check("rst2_any", 32'(bus.key_any), 0);
      reset = 1'b0;
      step(1);
      check("rst2_restart", 32'(bus.digit_sel), 32'h001);
      push(32'h00);
      push(32'h00);
      push(32'h00);
      show_digit("rst2_d1", 1);
      show_digit("rst2_d2", 2);
      show_digit("rst2_d3", 3);

      check("sb_drain", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
